// File: rtl/mem_io_bridge.sv
// mem_io_bridge: splits the processor memory port between a synchronous RAM
// and a 16-word memory-mapped I/O page. The page holds an output register, a
// synchronised switch input, a cycle counter and a FIFO-fed 8N1 serial
// transmitter.
// Optional feature: define TX_PARITY_EN to add an even-parity bit (11-bit frame).
module mem_io_bridge #(
   parameter logic [11:0] IO_BASE      = 12'hFF0,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          CLKS_PER_BIT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] m_addr,
   input  logic        m_rw,
   input  logic [15:0] m_data,
   output logic [15:0] m_q,
   output logic [11:0] ram_addr,
   output logic [15:0] ram_data,
   output logic        ram_wren,
   input  logic [15:0] ram_q,
   input  logic [15:0] in_port,
   output logic [15:0] out_port,
   output logic        tx,
   output logic        tx_busy
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [3:0]    DEPTH     = 4'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
`endif

   logic          ram_sel, io_sel, m_rw_q, wr_stb, io_wr;
   logic [11:0]   io_off;
   logic          wr_out, wr_txd, wr_cyc, wr_ctrl;
   logic [15:0]   in_s1, in_s2, cycle, status, io_rdata, io_rdata_q;
   logic          io_sel_q;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [3:0]    count;
   logic          overflow, empty, full, flush, push_ok, pop;
   tx_state_t     state, state_n;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic          bit_end;
   logic [7:0]    shift;
`ifdef TX_PARITY_EN
   logic          parity;
`endif

   assign ram_sel  = (m_addr < IO_BASE);
   assign io_sel   = ~ram_sel;
   assign io_off   = m_addr - IO_BASE;
   assign ram_addr = m_addr;
   assign ram_data = m_data;
   assign ram_wren = m_rw & ram_sel;

   // A store held over several clocks commits only on its first clock.
   assign wr_stb  = m_rw & ~m_rw_q;
   assign io_wr   = wr_stb & io_sel;
   assign wr_out  = io_wr & (io_off == 12'd0);
   assign wr_txd  = io_wr & (io_off == 12'd2);
   assign wr_cyc  = io_wr & (io_off == 12'd3);
   assign wr_ctrl = io_wr & (io_off == 12'd4);

   assign empty   = (count == 4'd0);
   assign full    = (count == DEPTH);
   assign flush   = wr_ctrl & m_data[1];
   assign push_ok = wr_txd & ~full & ~flush;
   assign pop     = (state == S_IDLE) & ~empty;
   assign tx_busy = (state != S_IDLE) | ~empty;
   assign bit_end = (baud_cnt == BAUD_LAST);
   assign status  = {overflow, tx_busy, full, empty, 8'h00, count};

   // Store edge detect, output register and free-running cycle counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_rw_q   <= 1'b0;
         out_port <= 16'h0000;
         cycle    <= 16'h0000;
      end else begin
         m_rw_q <= m_rw;
         if (wr_out) out_port <= m_data;
         cycle <= wr_cyc ? 16'h0000 : cycle + 16'd1;
      end
   end

   // Two-flop synchroniser for the asynchronous switch inputs
   always_ff @(posedge clock) begin
      in_s1 <= in_port;
      in_s2 <= in_s1;
   end

   // I/O read mux; unmapped offsets and write-only registers read as zero
   always_comb begin
      io_rdata = 16'h0000;
      if (io_sel) begin
         case (io_off)
            12'd0:   io_rdata = out_port;
            12'd1:   io_rdata = in_s2;
            12'd2:   io_rdata = status;
            12'd3:   io_rdata = cycle;
            default: io_rdata = 16'h0000;
         endcase
      end
   end

   // Read-path select, one clock behind the address to line up with the RAM
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) io_sel_q <= 1'b0;
      else        io_sel_q <= io_sel;
   end

   // Read-path data, captured every clock
   always_ff @(posedge clock) begin
      io_rdata_q <= io_rdata;
   end

   assign m_q = io_sel_q ? io_rdata_q : ram_q;

   // FIFO pointers, occupancy and sticky overflow; a full push is judged before any pop
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= 4'd0;
         overflow <= 1'b0;
      end else begin
         if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= 4'd0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count <= count + {3'b000, push_ok} - {3'b000, pop};
         end
         if (wr_ctrl & m_data[0])          overflow <= 1'b0;
         else if (wr_txd & full & ~flush)  overflow <= 1'b1;
      end
   end

   // FIFO storage
   always_ff @(posedge clock) begin
      if (push_ok) fifo_mem[wr_ptr] <= m_data[7:0];
   end

   // TX state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   // TX next state and line drive
   always_comb begin
      state_n = state;
      tx      = 1'b1;
      case (state)
         S_IDLE:  if (!empty) state_n = S_START;
         S_START: begin
            tx = 1'b0;
            if (bit_end) state_n = S_DATA;
         end
         S_DATA: begin
            tx = shift[0];
`ifdef TX_PARITY_EN
            if (bit_end && bit_cnt == 3'd7) state_n = S_PARITY;
`else
            if (bit_end && bit_cnt == 3'd7) state_n = S_STOP;
`endif
         end
`ifdef TX_PARITY_EN
         S_PARITY: begin
            tx = parity;
            if (bit_end) state_n = S_STOP;
         end
`endif
         S_STOP:  if (bit_end) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Baud and bit counters; both held at zero while idle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         baud_cnt <= '0;
         bit_cnt  <= 3'd0;
      end else if (state == S_IDLE) begin
         baud_cnt <= '0;
         bit_cnt  <= 3'd0;
      end else if (bit_end) begin
         baud_cnt <= '0;
         if (state == S_DATA) bit_cnt <= bit_cnt + 3'd1;
      end else begin
         baud_cnt <= baud_cnt + BW'(1);
      end
   end

   // Frame shift register, loaded on pop and shifted LSB first
   always_ff @(posedge clock) begin
      if (pop)                          shift <= fifo_mem[rd_ptr];
      else if (state == S_DATA && bit_end) shift <= {1'b0, shift[7:1]};
   end

`ifdef TX_PARITY_EN
   // Even parity of the byte being sent, captured with the pop
   always_ff @(posedge clock) begin
      if (pop) parity <= ^fifo_mem[rd_ptr];
   end
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: RAM/I/O routing, I/O registers, TX FIFO and serial frames.
module tb_mem_io_bridge;
   localparam logic [11:0] IO  = 12'hFF0;
   localparam int          CPB = 16;

   logic        clock, reset;
   logic [11:0] m_addr;
   logic        m_rw;
   logic [15:0] m_data, m_q;
   logic [11:0] ram_addr;
   logic [15:0] ram_data, ram_q;
   logic        ram_wren;
   logic [15:0] in_port, out_port;
   logic        tx, tx_busy;

   int checks = 0;
   int errors = 0;

   mem_io_bridge #(.IO_BASE(IO), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clock(clock), .reset(reset), .m_addr(m_addr), .m_rw(m_rw), .m_data(m_data),
      .m_q(m_q), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_q(ram_q), .in_port(in_port), .out_port(out_port), .tx(tx), .tx_busy(tx_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous RAM model: read data one clock after the address
   logic [15:0] ram [0:4095];
   always @(posedge clock) begin
      if (ram_wren) ram[ram_addr] <= ram_data;
      ram_q <= ram[ram_addr];
   end

   // Serial receiver sampling each bit in its middle
   int          rx_count = 0;
   logic [7:0]  rx_byte  = 8'h00;
   logic        rx_stop  = 1'b0;
   always begin
      @(negedge tx);
      repeat (CPB/2) @(posedge clock);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clock);
         rx_byte[i] = tx;
      end
`ifdef TX_PARITY_EN
      repeat (CPB) @(posedge clock);
`endif
      repeat (CPB) @(posedge clock);
      rx_stop = tx;
      rx_count++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic io_write(input logic [3:0] off, input logic [15:0] d);
      m_addr = IO + {8'h00, off};
      m_data = d;
      m_rw   = 1'b1;
      step();
      m_rw   = 1'b0;
      step();
   endtask

   task automatic io_read(input logic [3:0] off, output logic [15:0] v);
      m_addr = IO + {8'h00, off};
      m_rw   = 1'b0;
      step();
      v = m_q;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (tx_busy !== 1'b0 && n < limit) begin
         step();
         n++;
      end
   endtask

   logic [15:0] v, v1;
   int          r0, n;
   logic [7:0]  exp_byte;

   initial begin
      reset = 1'b0; m_addr = 12'h000; m_rw = 1'b0; m_data = 16'h0000; in_port = 16'hC3C3;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_out_port", out_port, 16'h0000);
      chk("rst_tx", {15'd0, tx}, 16'h0001);
      chk("rst_tx_busy", {15'd0, tx_busy}, 16'h0000);
      reset = 1'b1;
      step();
      io_read(4'd2, v);
      chk("status_after_reset", v, 16'h1000);

      // Cycle counter increments once per clock
      m_addr = IO + 12'd3;
      step(); v1 = m_q;
      step();
      chk("cycle_incr", m_q, v1 + 16'd1);
      io_write(4'd3, 16'hFFFF);
      chk("cycle_cleared", m_q, 16'h0000);
      step();
      chk("cycle_after_clear", m_q, 16'h0001);

      // OUT register
      m_addr = IO; m_data = 16'hA5A5; m_rw = 1'b1;
      #1;
      chk("out_no_ram_wren", {15'd0, ram_wren}, 16'h0000);
      chk("out_before_edge", out_port, 16'h0000);
      step();
      chk("out_port_loaded", out_port, 16'hA5A5);
      m_rw = 1'b0;
      step();
      chk("out_readback", m_q, 16'hA5A5);

      // RAM store and load
      m_addr = 12'h010; m_data = 16'h1234; m_rw = 1'b1;
      #1;
      chk("ram_wren_store", {15'd0, ram_wren}, 16'h0001);
      chk("ram_addr", {4'h0, ram_addr}, 16'h0010);
      step();
      m_rw = 1'b0;
      #1;
      chk("ram_wren_load", {15'd0, ram_wren}, 16'h0000);
      step();
      chk("ram_readback", m_q, 16'h1234);

      // Last RAM address below the I/O page
      m_addr = IO - 12'd1; m_rw = 1'b1;
      #1;
      chk("ram_boundary_wren", {15'd0, ram_wren}, 16'h0001);
      m_rw = 1'b0;
      step();

      // IN and unmapped offsets
      io_read(4'd1, v);
      chk("in_port_read", v, 16'hC3C3);
      io_read(4'd7, v);
      chk("unmapped_read", v, 16'h0000);

      // Single frame 0x55
      r0 = rx_count;
      io_write(4'd2, 16'h0055);
      chk("busy_after_push", {15'd0, tx_busy}, 16'h0001);
      n = 0;
      while (tx !== 1'b0 && n < 40) begin step(); n++; end
      chk("start_edge_seen", {15'd0, tx}, 16'h0000);
      repeat (CPB/2) step();
      chk("start_bit", {15'd0, tx}, 16'h0000);
      exp_byte = 8'h55;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) step();
         chk($sformatf("data_bit%0d", i), {15'd0, tx}, {15'd0, exp_byte[i]});
      end
`ifdef TX_PARITY_EN
      repeat (CPB) step();
      chk("parity_bit", {15'd0, tx}, 16'h0000);
`endif
      repeat (CPB) step();
      chk("stop_bit", {15'd0, tx}, 16'h0001);
      chk("busy_in_stop", {15'd0, tx_busy}, 16'h0001);
      repeat (CPB/2) step();
      chk("busy_after_stop", {15'd0, tx_busy}, 16'h0000);
      chk("rx_frames_one", 16'(rx_count - r0), 16'd1);
      chk("rx_byte_55", {8'h00, rx_byte}, 16'h0055);
      chk("rx_stop_55", {15'd0, rx_stop}, 16'h0001);

      // Overflow: ten pushes during the first frame, nine survive
      r0 = rx_count;
      for (int b = 1; b <= 10; b++) io_write(4'd2, 16'(b));
      io_read(4'd2, v);
      chk("status_overflow", v, 16'hE008);
      io_write(4'd4, 16'h0001);
      io_read(4'd2, v);
      chk("status_ovf_cleared", v, 16'h6008);
      wait_idle(3000);
      chk("overflow_drained", {15'd0, tx_busy}, 16'h0000);
      chk("rx_frames_nine", 16'(rx_count - r0), 16'd9);
      chk("rx_last_byte", {8'h00, rx_byte}, 16'h0009);

      // Held store pushes once; flush mid-frame empties the FIFO
      r0 = rx_count;
      io_write(4'd2, 16'h00A1);
      m_addr = IO + 12'd2; m_data = 16'h00B2; m_rw = 1'b1;
      repeat (40) step();
      m_rw = 1'b0;
      step();
      io_read(4'd2, v);
      chk("held_store_count", v, 16'h4001);
      io_write(4'd4, 16'h0002);
      io_read(4'd2, v);
      chk("status_flushed", v, 16'h5000);
      wait_idle(1000);
      chk("flush_drained", {15'd0, tx_busy}, 16'h0000);
      chk("rx_frames_flush", 16'(rx_count - r0), 16'd1);
      chk("rx_byte_a1", {8'h00, rx_byte}, 16'h00A1);

      // Reset in the middle of a frame
      io_write(4'd0, 16'h1111);
      io_write(4'd2, 16'h0033);
      repeat (30) step();
      chk("mid_frame_busy", {15'd0, tx_busy}, 16'h0001);
      reset = 1'b0;
      #1;
      chk("midrst_out_port", out_port, 16'h0000);
      chk("midrst_tx", {15'd0, tx}, 16'h0001);
      chk("midrst_tx_busy", {15'd0, tx_busy}, 16'h0000);
      repeat (2) step();
      reset = 1'b1;
      step();
      io_read(4'd2, v);
      chk("midrst_status", v, 16'h1000);
      m_addr = IO + 12'd3;
      step(); v1 = m_q;
      step();
      chk("midrst_cycle_incr", m_q, v1 + 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Memory-side neighbour of the processor. Consumes the processor's m_addr/m_rw/m_data and returns m_q.
- Routes each access either to the synchronous program/data RAM or to a small memory-mapped I/O page.
- The I/O page holds an output register, a synchronised switch input, a cycle counter, and a FIFO-buffered 8N1 serial transmitter.

Parameters:
- IO_BASE, 12'hFF0, first address of the I/O page; addresses >= IO_BASE select I/O, all others select RAM.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..8.
- CLKS_PER_BIT, 16, clocks per serial bit; must be >= 2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- m_addr  input  12  access address from processor
- m_rw  input  1  1 = write, 0 = read
- m_data  input  16  write data from processor
- m_q  output  16  read data to processor
- ram_addr  output  12  RAM address (combinational copy of m_addr)
- ram_data  output  16  RAM write data (combinational copy of m_data)
- ram_wren  output  1  RAM write enable
- ram_q  input  16  RAM read data, valid one clock after the address
- in_port  input  16  asynchronous switch inputs
- out_port  output  16  output register (LEDs)
- tx  output  1  serial line; idle high
- tx_busy  output  1  1 while a frame is shifting or the FIFO is non-empty

Behaviour:
- Reset values, applied asynchronously while reset = 0:
  - out_port = 0, tx = 1, tx_busy = 0.
  - FIFO empty, overflow = 0, counter = 0.
  - io_sel_q = 0, TX FSM in IDLE.
- Address decode:
  - ram_sel = (m_addr < IO_BASE); io_sel = ~ram_sel.
  - ram_wren = m_rw & ram_sel, a level; repeated writes of the same data are harmless.
- Write strobe:
  - m_rw_q registers m_rw.
  - wr_stb = m_rw & ~m_rw_q, so each processor store commits exactly one I/O write, on the first clock m_rw is high.
- Read path, latency 1 clock to match RAM:
  - io_sel_q <= io_sel and io_rdata_q <= I/O read mux, both every clock.
  - m_q = io_sel_q ? io_rdata_q : ram_q.
- I/O map, offsets from IO_BASE:
  - +0 OUT: a write loads out_port; a read returns out_port.
  - +1 IN: read only; returns in_port after a two-flop synchroniser. Writes are ignored.
  - +2 TXDATA: a write pushes m_data[7:0] into the FIFO. A read returns status:
    - [15] overflow
    - [14] tx_busy
    - [13] full
    - [12] empty
    - [3:0] count
    - all other bits 0
  - +3 CYCLE: a read returns the free-running 16-bit counter, which increments every clock and wraps FFFF -> 0000. A write clears it to 0 in that clock; the next clock it reads 1.
  - +4 CTRL: a write with bit0 = 1 clears overflow; a write with bit1 = 1 flushes the FIFO (count = 0; the frame in flight completes). Reads return 0.
  - +5..+15 unmapped: reads return 16'h0000; writes are ignored.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count register.
  - A push while full (evaluated before any same-cycle pop) is dropped and sets overflow (sticky).
  - Push and pop in the same cycle while non-empty leaves count unchanged.
  - A push into an empty FIFO is not poppable until the next clock; there is no bypass.
  - A flush and a push in the same cycle: the flush wins and the push is dropped without setting overflow.
- TX FSM (LSB first):
  - IDLE: tx = 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx = 0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: tx = shift[0] for CLKS_PER_BIT clocks per bit, 8 bits, bit counter 0..7; then go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT clocks, then IDLE. Back-to-back frames take a single IDLE clock between the stop bit and the next start bit.
  - tx_busy = (state != IDLE) | ~empty.
- Reset mid-frame: tx returns high immediately; FIFO contents are lost.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT clocks, giving an 11-bit frame.
- Undefined: frames are 10 bits (8N1) and the PARITY state does not exist.

Test Plan:
- Reset low mid-run -> out_port = 0000, tx = 1, status read = 16'h1000; after release, CYCLE reads increase by 1 per clock.
- Store 16'hA5A5 to IO_BASE+0, then load it -> out_port = A5A5 on the clock after the m_rw rise; m_q = A5A5 one clock after the address; ram_wren stays 0.
- Store to 12'h010 and then load it -> ram_wren = 1 only during the store, with ram_addr = 010; load m_q equals ram_q; io_sel_q = 0.
- Push 8'h55 with CLKS_PER_BIT = 16 -> tx shows 0, then 1,0,1,0,1,0,1,0, then 1 (plus parity bit 0 before the stop bit if TX_PARITY_EN), each 16 clocks; tx_busy falls after the stop bit.
- Push 10 bytes back-to-back with FIFO_DEPTH = 8 while the first frame shifts -> 9 bytes transmitted; overflow = 1 in status; a CTRL write of 1 clears it to 0.
- Hold m_rw high for 40 clocks on TXDATA -> exactly one push (count = 1); CTRL write of 2 mid-frame -> count = 0 and the current frame still finishes.
